// File: rtl/orient_scan_gen_if.sv
// Interface bundling the scan-control inputs and address outputs of
// orient_scan_gen. The optional loop input exists only when SCAN_LOOP_EN is
// defined.
interface orient_scan_gen_if #(
    parameter int DIM_LOG2 = 5
);
    localparam int AW = 2 * DIM_LOG2;

    logic          start;
    logic [1:0]    mode;
    logic          clear;
    logic          advance;
`ifdef SCAN_LOOP_EN
    logic          loop;
`endif
    logic [AW-1:0] addr;
    logic          busy;
    logic          last;
    logic          done;

`ifdef SCAN_LOOP_EN
    // Orientation decoder / frame-buffer side.
    modport master (output start, mode, clear, advance, loop,
                    input  addr, busy, last, done);
    // Address generator side.
    modport slave  (input  start, mode, clear, advance, loop,
                    output addr, busy, last, done);
`else
    // Orientation decoder / frame-buffer side.
    modport master (output start, mode, clear, advance,
                    input  addr, busy, last, done);
    // Address generator side.
    modport slave  (input  start, mode, clear, advance,
                    output addr, busy, last, done);
`endif
endinterface

// File: rtl/orient_scan_gen.sv
// orient_scan_gen: raster-address generator for a 2^DIM_LOG2 square grid.
// Emits one address per accepted step in one of four scan orders, selected
// at start. Optional macro SCAN_LOOP_EN adds a loop input that restarts the
// scan after the final address instead of terminating in DONE.
module orient_scan_gen #(
    parameter int DIM_LOG2 = 5
) (
    input  logic              clk,
    input  logic              reset,
    orient_scan_gen_if.slave  bus
);
    localparam int AW = 2 * DIM_LOG2;
    localparam logic [DIM_LOG2-1:0] IDX_ZERO = '0;
    localparam logic [DIM_LOG2-1:0] IDX_MAX  = '1;
    localparam logic [DIM_LOG2-1:0] IDX_ONE  = {{(DIM_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [DIM_LOG2-1:0] row_r, row_nxt_s;
    logic [DIM_LOG2-1:0] col_r, col_nxt_s;
    logic [1:0]          mode_r, mode_nxt_s;
    logic                done_r, done_nxt_s;
    logic                at_final_s;
    logic                last_s;

    // First {row, col} position of each scan order.
    function automatic logic [AW-1:0] first_pos(input logic [1:0] m);
        case (m)
            2'd0:    first_pos = {IDX_ZERO, IDX_ZERO};
            2'd1:    first_pos = {IDX_MAX,  IDX_MAX};
            2'd2:    first_pos = {IDX_ZERO, IDX_MAX};
            2'd3:    first_pos = {IDX_ZERO, IDX_ZERO};
            default: first_pos = {IDX_ZERO, IDX_ZERO};
        endcase
    endfunction

    // Successor {row, col} for a non-final position of each scan order.
    function automatic logic [AW-1:0] next_pos(input logic [1:0] m,
                                               input logic [DIM_LOG2-1:0] r,
                                               input logic [DIM_LOG2-1:0] c);
        case (m)
            2'd0:    next_pos = (c == IDX_MAX)  ? {r + IDX_ONE, IDX_ZERO} : {r, c + IDX_ONE};
            2'd1:    next_pos = (c == IDX_ZERO) ? {r - IDX_ONE, IDX_MAX}  : {r, c - IDX_ONE};
            2'd2:    next_pos = (r == IDX_MAX)  ? {IDX_ZERO, c - IDX_ONE} : {r + IDX_ONE, c};
            2'd3:    next_pos = (r == IDX_MAX)  ? {IDX_ZERO, c + IDX_ONE} : {r + IDX_ONE, c};
            default: next_pos = {r, c};
        endcase
    endfunction

    // Detect the final position of the latched scan order.
    always_comb begin
        at_final_s = 1'b0;
        case (mode_r)
            2'd0:    at_final_s = (row_r == IDX_MAX)  && (col_r == IDX_MAX);
            2'd1:    at_final_s = (row_r == IDX_ZERO) && (col_r == IDX_ZERO);
            2'd2:    at_final_s = (row_r == IDX_MAX)  && (col_r == IDX_ZERO);
            2'd3:    at_final_s = (row_r == IDX_MAX)  && (col_r == IDX_MAX);
            default: at_final_s = 1'b0;
        endcase
        last_s = (state_r == ST_BUSY) && at_final_s;
    end

    // Next-state, position and done-pulse logic; clear overrides start/advance.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        mode_nxt_s  = mode_r;
        done_nxt_s  = 1'b0;
        if (bus.clear) begin
            state_nxt_s = ST_IDLE;
            row_nxt_s   = IDX_ZERO;
            col_nxt_s   = IDX_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_nxt_s            = ST_BUSY;
                        mode_nxt_s             = bus.mode;
                        {row_nxt_s, col_nxt_s} = first_pos(bus.mode);
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_BUSY: begin
                    if (bus.advance && last_s) begin
                        // The done pulse also marks a frame boundary when looping.
                        done_nxt_s = 1'b1;
`ifdef SCAN_LOOP_EN
                        if (bus.loop) begin
                            {row_nxt_s, col_nxt_s} = first_pos(mode_r);
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
`else
                        state_nxt_s = ST_DONE;
`endif
                    end else if (bus.advance) begin
                        {row_nxt_s, col_nxt_s} = next_pos(mode_r, row_r, col_r);
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    row_nxt_s   = IDX_ZERO;
                    col_nxt_s   = IDX_ZERO;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            row_r   <= IDX_ZERO;
            col_r   <= IDX_ZERO;
            mode_r  <= 2'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            mode_r  <= mode_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign bus.addr = {row_r, col_r};
    assign bus.busy = (state_r == ST_BUSY);
    assign bus.last = last_s;
    assign bus.done = done_r;

endmodule

// File: tb/tb_orient_scan_gen.sv
// Directed testbench for orient_scan_gen with DIM_LOG2 = 5 (32x32 grid).
module tb_orient_scan_gen;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    orient_scan_gen_if #(.DIM_LOG2(5)) bus ();

    orient_scan_gen #(.DIM_LOG2(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address of the k-th step of scan order m on a 32x32 grid.
    function automatic int exp_addr(input int m, input int k);
        case (m)
            0:       exp_addr = k;
            1:       exp_addr = 1023 - k;
            2:       exp_addr = (k % 32) * 32 + (31 - k / 32);
            default: exp_addr = (k % 32) * 32 + (k / 32);
        endcase
    endfunction

    // Full scan with advance held high; checks every address and last flag.
    task automatic run_full(input int m);
        bus.start = 1'b1; bus.mode = 2'(m); bus.advance = 1'b0;
        tick();
        bus.start = 1'b0;
        check($sformatf("m%0d_start_busy", m), 32'(bus.busy), 32'd1);
        bus.advance = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            check($sformatf("m%0d_addr_k%0d", m, k), 32'(bus.addr), 32'(exp_addr(m, k)));
            check($sformatf("m%0d_last_k%0d", m, k), 32'(bus.last), (k == 1023) ? 32'd1 : 32'd0);
            tick();
        end
        check($sformatf("m%0d_end_busy", m), 32'(bus.busy), 32'd0);
        check($sformatf("m%0d_end_done", m), 32'(bus.done), 32'd1);
        check($sformatf("m%0d_end_addr", m), 32'(bus.addr), 32'(exp_addr(m, 1023)));
        bus.advance = 1'b0;
        tick();
        check($sformatf("m%0d_done_once", m), 32'(bus.done), 32'd0);
        check($sformatf("m%0d_hold_addr", m), 32'(bus.addr), 32'(exp_addr(m, 1023)));
    endtask

    initial begin
        int n, k;
        logic [9:0] prev;
        logic adv;
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.mode = 2'd0; bus.clear = 1'b0; bus.advance = 1'b0;
`ifdef SCAN_LOOP_EN
        bus.loop = 1'b0;
`endif
        tick(); tick();
        check("rst_addr", 32'(bus.addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_last", 32'(bus.last), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;

        // advance in IDLE is ignored
        bus.advance = 1'b1; tick();
        check("idle_adv_addr", 32'(bus.addr), 32'd0);
        check("idle_adv_busy", 32'(bus.busy), 32'd0);
        check("idle_adv_done", 32'(bus.done), 32'd0);
        bus.advance = 1'b0;

        for (int m = 0; m < 4; m++) run_full(m);

        // Mode 0 with advance toggling 0/1: 2048 cycles, addr holds on idle cycles
        bus.start = 1'b1; bus.mode = 2'd0; tick();
        bus.start = 1'b0;
        n = 0; k = 0;
        while (bus.busy && n < 5000) begin
            adv = (n % 2) == 1;
            bus.advance = adv;
            prev = bus.addr;
            tick();
            n++;
            if (adv) begin
                k++;
                check("tog_step", 32'(bus.addr), (k < 1024) ? 32'(k) : 32'd1023);
            end else begin
                check("tog_hold", 32'(bus.addr), 32'(prev));
            end
        end
        check("tog_cycles", 32'(n), 32'd2048);
        check("tog_done", 32'(bus.done), 32'd1);
        bus.advance = 1'b0;

        // start while BUSY with a different mode is ignored
        bus.start = 1'b1; bus.mode = 2'd1; tick();
        bus.start = 1'b0; bus.advance = 1'b1; tick();
        check("sb_k1", 32'(bus.addr), 32'd1022);
        bus.start = 1'b1; bus.mode = 2'd2; tick();
        bus.start = 1'b0;
        check("sb_ignored", 32'(bus.addr), 32'd1021);
        check("sb_busy", 32'(bus.busy), 32'd1);
        for (int j = 2; j < 1024; j++) begin
            check("sb_addr", 32'(bus.addr), 32'(exp_addr(1, j)));
            tick();
        end
        check("sb_done", 32'(bus.done), 32'd1);
        // start on the done cycle is accepted
        bus.start = 1'b1; bus.mode = 2'd2; bus.advance = 1'b0; tick();
        bus.start = 1'b0;
        check("sd_busy", 32'(bus.busy), 32'd1);
        check("sd_addr", 32'(bus.addr), 32'd31);
        check("sd_done", 32'(bus.done), 32'd0);

        // clear with advance at addr 95 in mode 2
        bus.advance = 1'b1; tick(); tick();
        check("clr_pre_addr", 32'(bus.addr), 32'd95);
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0; bus.advance = 1'b0;
        check("clr_addr", 32'(bus.addr), 32'd0);
        check("clr_busy", 32'(bus.busy), 32'd0);
        check("clr_done", 32'(bus.done), 32'd0);
        check("clr_last", 32'(bus.last), 32'd0);
        tick();
        check("clr_done2", 32'(bus.done), 32'd0);

        // clear with advance on the final address: no done pulse
        bus.start = 1'b1; bus.mode = 2'd1; tick();
        bus.start = 1'b0; bus.advance = 1'b1;
        for (int j = 0; j < 1023; j++) tick();
        check("cl_last_flag", 32'(bus.last), 32'd1);
        check("cl_last_addr", 32'(bus.addr), 32'd0);
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0; bus.advance = 1'b0;
        check("cl_last_done", 32'(bus.done), 32'd0);
        check("cl_last_busy", 32'(bus.busy), 32'd0);

        // reset mid-scan
        bus.start = 1'b1; bus.mode = 2'd3; tick();
        bus.start = 1'b0; bus.advance = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        check("rm_pre_addr", 32'(bus.addr), 32'd160);
        reset = 1'b1; tick();
        reset = 1'b0; bus.advance = 1'b0;
        check("rm_addr", 32'(bus.addr), 32'd0);
        check("rm_busy", 32'(bus.busy), 32'd0);
        check("rm_done", 32'(bus.done), 32'd0);

`ifdef SCAN_LOOP_EN
        // loop: after the final address the scan restarts with a done marker
        bus.loop = 1'b1;
        bus.start = 1'b1; bus.mode = 2'd3; tick();
        bus.start = 1'b0; bus.advance = 1'b1;
        for (int j = 0; j < 1024; j++) begin
            check("lp1_addr", 32'(bus.addr), 32'(exp_addr(3, j)));
            tick();
        end
        check("lp_wrap_addr", 32'(bus.addr), 32'd0);
        check("lp_wrap_busy", 32'(bus.busy), 32'd1);
        check("lp_wrap_done", 32'(bus.done), 32'd1);
        bus.loop = 1'b0;
        for (int j = 0; j < 1024; j++) begin
            check("lp2_addr", 32'(bus.addr), 32'(exp_addr(3, j)));
            if (j == 1) check("lp_done_once", 32'(bus.done), 32'd0);
            tick();
        end
        check("lp_end_busy", 32'(bus.busy), 32'd0);
        check("lp_end_done", 32'(bus.done), 32'd1);
        bus.advance = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/orient_scan_gen.md
Name: orient_scan_gen

Overview:
- Parametrised raster-address generator for the line-follower image grid (2^DIM_LOG2 x 2^DIM_LOG2 pixels).
- Produces one pixel address per accepted step, in one of four scan orders selected per scan. This covers all bot orientations with one block.
- Sits between the orientation decoder (drives mode/start) and the frame-buffer read port (consumes addr on advance).

Parameters:
- DIM_LOG2, 5, log2 of grid side N (N = 2^DIM_LOG2). Address width AW = 2*DIM_LOG2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a scan with the current mode; honoured only in IDLE or DONE
- mode  in  2  scan order; sampled on accepted start
- clear  in  1  abort scan, return to IDLE
- advance  in  1  consumer accepted current addr; step to next
- addr  out  AW  current pixel address = row*N + col
- busy  out  1  scan active, addr valid
- last  out  1  busy and addr is the final address of the scan (combinational from state)
- done  out  1  one-cycle pulse after the final address is accepted

Behaviour:
- Internal registers: row and col (DIM_LOG2 bits each), latched mode (2 bits), state.
- addr is {row, col}.
- States: IDLE, BUSY, DONE.
- Reset values: state IDLE, row 0, col 0, addr 0, busy 0, last 0, done 0, latched mode 0.
- Modes and iteration order:
  - 0: row-major ascending. First 0; col increments; at col N-1, col->0 and row++. Final N*N-1.
  - 1: row-major descending. First N*N-1; col decrements; at col 0, col->N-1 and row--. Final 0.
  - 2: column-major, col descending, row ascending. First N-1 (row 0, col N-1); row increments; at row N-1, row->0 and col--. Final (N-1)*N. For N=32: 31, 63, ..., 1023, 30, 62, ..., 992.
  - 3: column-major, col ascending, row ascending. First 0; row increments; at row N-1, row->0 and col++. Final N*N-1.
- IDLE/DONE + start: next cycle state BUSY, busy=1, row/col loaded with the mode's first position, mode latched.
- BUSY + advance, not last: next cycle addr moves to the next position. Latency is 1 cycle per step; back-to-back advance gives a new addr every cycle.
- BUSY + advance + last: next cycle state DONE, busy=0, done=1 for exactly one cycle, addr holds the final value.
- BUSY without advance: all outputs hold.
- DONE: done is high only on the first DONE cycle; addr keeps its final value until the next start.
- Priority: reset > clear > start/advance.
  - clear in any state: next cycle IDLE, row=col=0, busy=0, done=0.
  - clear with advance on the last address: no done pulse.
- start while BUSY is ignored, and mode changes while BUSY are ignored (the latched mode is used).
- advance in IDLE or DONE is ignored.
- A start in the same cycle as the done pulse (DONE state) is accepted.
- reset mid-scan behaves like clear, plus latched mode returns to 0.
- Arithmetic: row/col wrap modulo N only at the transitions defined above. No state ever produces an address outside 0..N*N-1.

Optional Feature:
- SCAN_LOOP_EN: adds input port loop (1 bit).
  - With the macro: BUSY + advance + last + loop=1 makes the next cycle reload the first position of the latched mode. State stays BUSY and done pulses for one cycle (frame marker). loop=0 behaves as the base design.
  - Without the macro: the port is absent and the scan always terminates in DONE.

Test Plan:
- DIM_LOG2=5, mode 2, start, advance held high -> addr sequence 31, 63, ..., 1023, 30, 62, ..., 0, 32, ..., 992. That is 1024 addresses; last=1 only at 992; busy falls and done=1 one cycle after 992 is accepted.
- mode 1, start, advance high -> 1023, 1022, ..., 0; last at 0; then done pulse. Mode 0 and mode 3 checked likewise (mode 3: 0, 32, ..., 992, 1, 33, ..., 1023).
- mode 0, advance toggled 1/0 -> addr changes only on cycles after advance=1; 2048 cycles to finish; addr holds while advance=0.
- mode 2, clear asserted at addr 95 with advance=1 -> next cycle IDLE, addr 0, busy 0, no done. Reset asserted mid-scan -> same, latched mode 0.
- start while BUSY with a different mode -> ignored, order unchanged. start on the done cycle -> BUSY next cycle at the new mode's first address.
- SCAN_LOOP_EN, mode 3, loop=1 -> after 1023 is accepted, addr=0 next cycle, busy stays 1, done pulses once. loop=0 on the second pass -> DONE.
